msoc_burst_mem: RTL and testbench

MSOC_BURST_MEM -- requirements
Module: msoc_burst_mem

---
 rtl/msoc_burst_mem_if.sv | 30 +++
 rtl/msoc_burst_mem.sv | 129 ++++++++++++
 tb/tb_msoc_burst_mem.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/msoc_burst_mem_if.sv
// Bus bundle for msoc_burst_mem: command, byte-lane write, read burst.
// master drives commands; slave returns waitrequest and read beats.
interface msoc_burst_mem_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 14,
  parameter int BURST_W = 4
);
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W/8-1:0]   byteenable;
  logic [DATA_W-1:0]     writedata;
  logic [BURST_W-1:0]    burstcount;
  logic                  waitrequest;
  logic [DATA_W-1:0]     readdata;
  logic                  readdatavalid;

  modport master (
    output chipselect, read, write, address,
    output byteenable, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  chipselect, read, write, address,
    input  byteenable, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/msoc_burst_mem.sv
// Burst RAM slave: single-beat byte-lane writes, pipelined read bursts.
// Ports: clk, reset (sync high), clken, reset_req (stall), bus (slave).
module msoc_burst_mem #(
  parameter int    DATA_W       = 32,
  parameter int    ADDR_W       = 14,
  parameter int    BURST_W      = 4,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "MSoC_mem.hex"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clken,
  input  logic            reset_req,
  msoc_burst_mem_if.slave bus
);
  localparam int BE_W      = DATA_W / 8;
  localparam int MAX_BURST = 2 ** (BURST_W - 1);

  typedef enum logic {IDLE, RBURST} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  cur_addr, cur_addr_nx;
  logic [ADDR_W-1:0]  iss_addr;
  logic [BURST_W-1:0] left, left_nx;
  logic [BURST_W-1:0] eff_n;
  logic               stall;
  logic               accept;
  logic               wr_acc;
  logic               rd_acc;
  logic               issue;
  logic               v1, v2;
  logic               rdv;
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  out_q;
  logic [DATA_W-1:0]  hold_q;
  logic [DATA_W-1:0]  pipe_data;
  logic [DATA_W-1:0]  mem [2**ADDR_W];

  // The image named by INIT_FILE is bound to the RAM by the FPGA
  // memory flow; no logic depends on it here.
  if (INIT_FILE != "") begin : g_image
  end

  assign stall = ~clken | reset_req;
  assign bus.waitrequest = stall | (state == RBURST);

  // Write wins over a simultaneous read; reset blocks acceptance.
  assign accept = bus.chipselect & (bus.read | bus.write)
                & ~bus.waitrequest & ~reset;
  assign wr_acc = accept & bus.write;
  assign rd_acc = accept & ~bus.write;

  assign issue = rd_acc
               | ((state == RBURST) & ~stall & ~reset);
  assign iss_addr = rd_acc ? bus.address : cur_addr;

  always_comb begin
    eff_n = bus.burstcount;
    if (bus.burstcount == '0)
      eff_n = BURST_W'(1);
    else if (bus.burstcount > BURST_W'(MAX_BURST))
      eff_n = BURST_W'(MAX_BURST);
  end

  always_comb begin
    state_nx    = state;
    cur_addr_nx = cur_addr;
    left_nx     = left;
    unique case (state)
      IDLE: begin
        if (rd_acc) begin
          cur_addr_nx = bus.address + 1'b1;
          left_nx     = eff_n - 1'b1;
          if (eff_n != BURST_W'(1))
            state_nx = RBURST;
        end
      end
      RBURST: begin
        if (!stall) begin
          cur_addr_nx = cur_addr + 1'b1;
          left_nx     = left - 1'b1;
          if (left == BURST_W'(1))
            state_nx = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cur_addr <= '0;
      left     <= '0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      ram_q    <= '0;
      out_q    <= '0;
      hold_q   <= '0;
    end else if (!stall) begin
      state    <= state_nx;
      cur_addr <= cur_addr_nx;
      left     <= left_nx;
      v1       <= issue;
      v2       <= v1;
      if (issue)
        ram_q <= mem[iss_addr];
      if (v1)
        out_q <= ram_q;
      if (rdv)
        hold_q <= pipe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.byteenable[i])
          mem[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  // A pending beat is only presented on an unstalled, non-reset cycle;
  // otherwise readdata keeps the last beat actually delivered.
  assign pipe_data = (READ_LATENCY == 2) ? out_q : ram_q;
  assign rdv = ((READ_LATENCY == 2) ? v2 : v1) & ~stall & ~reset;
  assign bus.readdatavalid = rdv;
  assign bus.readdata = rdv ? pipe_data : hold_q;
endmodule

// File: tb/tb_msoc_burst_mem.sv
// Directed bench for msoc_burst_mem, latency 1 and 2 side by side.
// Both instances see identical stimulus; beats are logged per cycle.
module tb_msoc_burst_mem;
  logic        clk;
  logic        reset;
  logic        clken;
  logic        reset_req;
  logic        cs, rd, wr;
  logic [13:0] addr;
  logic [31:0] wdata;
  logic [3:0]  ben;
  logic [3:0]  bcnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int wcnt = 0;
  int a, b, c;
  int exp_t[4];

  logic [31:0] d1[$], d2[$];
  int          c1[$], c2[$];

  msoc_burst_mem_if #(.DATA_W(32), .ADDR_W(14), .BURST_W(4)) b1 ();
  msoc_burst_mem_if #(.DATA_W(32), .ADDR_W(14), .BURST_W(4)) b2 ();

  assign b1.chipselect = cs;
  assign b1.read       = rd;
  assign b1.write      = wr;
  assign b1.address    = addr;
  assign b1.byteenable = ben;
  assign b1.writedata  = wdata;
  assign b1.burstcount = bcnt;
  assign b2.chipselect = cs;
  assign b2.read       = rd;
  assign b2.write      = wr;
  assign b2.address    = addr;
  assign b2.byteenable = ben;
  assign b2.writedata  = wdata;
  assign b2.burstcount = bcnt;

  msoc_burst_mem #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .clken(clken),
    .reset_req(reset_req), .bus(b1)
  );

  msoc_burst_mem #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .reset(reset), .clken(clken),
    .reset_req(reset_req), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (b1.readdatavalid) begin
      d1.push_back(b1.readdata);
      c1.push_back(cyc);
    end
    if (b2.readdatavalid) begin
      d2.push_back(b2.readdata);
      c2.push_back(cyc);
    end
    if (b1.waitrequest && clken && !reset_req)
      wcnt++;
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear();
    d1.delete();
    c1.delete();
    d2.delete();
    c2.delete();
    wcnt = 0;
  endtask

  task automatic cmd(input logic r, input logic w,
                     input logic [13:0] ca, input logic [31:0] cd,
                     input logic [3:0] cbe, input logic [3:0] cbc,
                     output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    cs = 1'b1; rd = r; wr = w;
    addr = ca; wdata = cd; ben = cbe; bcnt = cbc;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!b1.waitrequest) begin
        ok = 1'b1;
        acc = cyc;
      end
    end
    if (!ok)
      check("accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0; ben = '0; bcnt = '0;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rdv1", b1.readdatavalid, 0);
    check("rst_rdata1", b1.readdata, 0);
    check("rst_wait1", b1.waitrequest, 0);
    check("rst_rdv2", b2.readdatavalid, 0);
    tick(1);
    clken = 1'b0;
    @(negedge clk);
    check("stall_clken_wait", b1.waitrequest, 1);
    tick(1);
    clken = 1'b1;
    reset_req = 1'b1;
    @(negedge clk);
    check("stall_rreq_wait", b1.waitrequest, 1);
    tick(1);
    reset_req = 1'b0;

    // byte-lane write then single read
    cmd(0, 1, 14'h0010, 32'hDEADBEEF, 4'hF, 4'd3, a);
    cmd(0, 1, 14'h0010, 32'h000000AA, 4'h1, 4'd0, a);
    clear();
    cmd(1, 0, 14'h0010, 32'h0, 4'h0, 4'd1, a);
    tick(4);
    check("be_n1", d1.size(), 1);
    check("be_d1", d1[0], 32'hDEADBEAA);
    check("be_t1", c1[0], a + 1);
    check("be_d2", d2[0], 32'hDEADBEAA);
    check("be_t2", c2[0], a + 2);

    // wrapping 4-beat burst
    cmd(0, 1, 14'h3FFE, 32'd1, 4'hF, 4'd0, a);
    cmd(0, 1, 14'h3FFF, 32'd2, 4'hF, 4'd0, a);
    cmd(0, 1, 14'h0000, 32'd3, 4'hF, 4'd0, a);
    cmd(0, 1, 14'h0001, 32'd4, 4'hF, 4'd0, a);
    clear();
    cmd(1, 0, 14'h3FFE, 32'h0, 4'h0, 4'd4, a);
    tick(6);
    check("wrap_wait", wcnt, 3);
    check("wrap_n1", d1.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_d1_%0d", i), d1[i], i + 1);
    check("wrap_t_first", c1[0], a + 1);
    check("wrap_t_last", c1[3], a + 4);
    check("wrap_d2_3", d2[3], 4);
    check("wrap_t2_first", c2[0], a + 2);

    // burstcount clamping
    clear();
    cmd(1, 0, 14'h0010, 32'h0, 4'h0, 4'd0, a);
    tick(5);
    check("bc0_n", d1.size(), 1);
    check("bc0_d", d1[0], 32'hDEADBEAA);
    clear();
    cmd(1, 0, 14'h3FFE, 32'h0, 4'h0, 4'd15, a);
    tick(12);
    check("bc15_n1", d1.size(), 8);
    check("bc15_n2", d2.size(), 8);
    check("bc15_wait", wcnt, 7);

    // clken dropped for two cycles after beat 1 is issued
    clear();
    cmd(1, 0, 14'h3FFE, 32'h0, 4'h0, 4'd4, a);
    tick(1);
    clken = 1'b0;
    @(negedge clk);
    check("stall_rdv1", b1.readdatavalid, 0);
    check("stall_hold1", b1.readdata, 1);
    tick(2);
    clken = 1'b1;
    tick(6);
    check("stall_n1", d1.size(), 4);
    check("stall_n2", d2.size(), 4);
    exp_t = '{a + 1, a + 4, a + 5, a + 6};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_d1_%0d", i), d1[i], i + 1);
      check($sformatf("stall_t1_%0d", i), c1[i], exp_t[i]);
    end
    exp_t = '{a + 4, a + 5, a + 6, a + 7};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_d2_%0d", i), d2[i], i + 1);
      check($sformatf("stall_t2_%0d", i), c2[i], exp_t[i]);
    end

    // reset in the middle of an 8-beat burst
    clear();
    cmd(1, 0, 14'h3FFE, 32'h0, 4'h0, 4'd8, a);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_wait", b1.waitrequest, 0);
    check("abort_rdv1", b1.readdatavalid, 0);
    check("abort_rdv2", b2.readdatavalid, 0);
    tick(8);
    check("abort_n1", d1.size(), 1);
    check("abort_n2", d2.size(), 0);
    clear();
    cmd(1, 0, 14'h0010, 32'h0, 4'h0, 4'd1, a);
    tick(4);
    check("abort_after_d1", d1[0], 32'hDEADBEAA);
    check("abort_after_d2", d2[0], 32'hDEADBEAA);

    // read and write together act as a write
    clear();
    cmd(1, 1, 14'h0020, 32'h12345678, 4'hF, 4'd4, a);
    tick(5);
    check("rw_n1", d1.size(), 0);
    check("rw_n2", d2.size(), 0);
    check("rw_wait", wcnt, 0);

    // command right after burst exit, write while beat in flight
    clear();
    cmd(1, 0, 14'h3FFE, 32'h0, 4'h0, 4'd2, a);
    cmd(1, 0, 14'h0020, 32'h0, 4'h0, 4'd1, b);
    cmd(0, 1, 14'h0020, 32'hCAFEF00D, 4'hF, 4'd0, c);
    tick(5);
    check("b2b_acc", b, a + 2);
    check("b2b_n1", d1.size(), 3);
    check("b2b_d1_2", d1[2], 32'h12345678);
    check("b2b_t1_2", c1[2], a + 3);
    check("b2b_d2_2", d2[2], 32'h12345678);
    check("b2b_t2_2", c2[2], a + 4);
    clear();
    cmd(1, 0, 14'h0020, 32'h0, 4'h0, 4'd1, a);
    tick(4);
    check("late_wr_d1", d1[0], 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
